// File: rtl/phy_tx_serial_if.sv
// Parallel-in / dual-lane serial-out bundle for phy_tx_serial.
// The master presents words; the slave (the serializer) drives the lanes and status.
interface phy_tx_serial_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out0;
  logic        data_out1;
  logic        frame_out;
  logic        idle_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out0, data_out1, frame_out, idle_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out0, data_out1, frame_out, idle_out
  );
endinterface

// File: rtl/phy_tx_serial.sv
// Two-lane serializer: 32-bit words are striped across lane 0 / lane 1 through
// one staging slot per lane and shifted out MSB first in frame-aligned 32-bit frames.
module phy_tx_serial #(
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input logic             clk_32f,
  input logic             reset_L,
  phy_tx_serial_if.slave  bus
);

  localparam logic [31:0] IDLE_WORD = {4{IDLE_BYTE}};

  logic [4:0]  bit_cnt;
  logic [31:0] slot_data [2];
  logic [1:0]  slot_vld;
  logic        wr_sel;
  logic [31:0] shifter [2];
  logic [1:0]  idle_ld;
  logic        frame_end;
  logic        accept;

  assign frame_end     = (bit_cnt == 5'd31);
  assign bus.ready_out = ~slot_vld[wr_sel];
  assign accept        = bus.valid_in & bus.ready_out;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt <= 5'd0;
    end else begin
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Every full slot is drained into its shifter at the frame boundary; a write into an
  // empty slot on that same edge lands after the clear, so it waits for the next frame.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      slot_vld <= 2'b00;
      wr_sel   <= 1'b0;
    end else begin
      if (frame_end) begin
        slot_vld <= 2'b00;
      end
      if (accept) begin
        slot_vld[wr_sel] <= 1'b1;
        wr_sel           <= ~wr_sel;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (accept) begin
      slot_data[wr_sel] <= bus.data_in;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        shifter[i] <= IDLE_WORD;
      end
      idle_ld <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (frame_end) begin
          shifter[i] <= slot_vld[i] ? slot_data[i] : IDLE_WORD;
          idle_ld[i] <= ~slot_vld[i];
        end else begin
          shifter[i] <= {shifter[i][30:0], 1'b0};
        end
      end
    end
  end

  assign bus.data_out0 = shifter[0][31];
  assign bus.data_out1 = shifter[1][31];
  assign bus.frame_out = (bit_cnt == 5'd0);
  assign bus.idle_out  = ~(|slot_vld) & (&idle_ld);

endmodule

// File: tb/tb_phy_tx_serial.sv
// Directed bench for phy_tx_serial: per-scenario tasks with hand-computed frames
// checked against a negedge lane monitor aligned to an independent bit counter.
module tb_phy_tx_serial;

  logic clk_32f = 1'b0;
  logic reset_L;
  int   checks = 0;
  int   errors = 0;

  logic [4:0]  tb_bit;
  logic [31:0] mon0, mon1;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] idle_pat;

  phy_tx_serial_if bus ();

  phy_tx_serial #(.IDLE_BYTE(8'hBC)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  always @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) tb_bit <= 5'd0;
    else          tb_bit <= tb_bit + 5'd1;
  end

  // Assemble each lane's 32 serial bits into a word, pushed at the last bit of a frame.
  always @(negedge clk_32f) begin
    if (reset_L) begin
      mon0 <= {mon0[30:0], bus.data_out0};
      mon1 <= {mon1[30:0], bus.data_out1};
      if (tb_bit == 5'd31) begin
        q0.push_back({mon0[30:0], bus.data_out0});
        q1.push_back({mon1[30:0], bus.data_out1});
      end
    end
  end

  task automatic wait_bit(input logic [4:0] b);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_32f);
      if (tb_bit == b) break;
    end
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    repeat (3) @(negedge clk_32f);
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready_out); end
    checks++; if (bus.data_out0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_d0: got %b expected 1", bus.data_out0); end
    checks++; if (bus.data_out1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_d1: got %b expected 1", bus.data_out1); end
    checks++; if (bus.frame_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_frame: got %b expected 1", bus.frame_out); end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 1", bus.idle_out); end
    reset_L = 1'b1;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 64; c++) begin
      checks++; if (bus.data_out0 !== idle_pat[31 - tb_bit]) begin errors++; $display("[TB] FAIL idle_d0 bit %0d: got %b expected %b", tb_bit, bus.data_out0, idle_pat[31 - tb_bit]); end
      checks++; if (bus.data_out1 !== idle_pat[31 - tb_bit]) begin errors++; $display("[TB] FAIL idle_d1 bit %0d: got %b expected %b", tb_bit, bus.data_out1, idle_pat[31 - tb_bit]); end
      checks++; if (bus.frame_out !== (tb_bit == 5'd0)) begin errors++; $display("[TB] FAIL idle_frame bit %0d: got %b expected %b", tb_bit, bus.frame_out, (tb_bit == 5'd0)); end
      checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("[TB] FAIL idle_flag bit %0d: got %b expected 1", tb_bit, bus.idle_out); end
      @(negedge clk_32f);
    end
  endtask

  task automatic test_two_words;
    int base;
    wait_bit(5'd2);
    base = q0.size();
    bus.valid_in = 1'b1; bus.data_in = 32'hDEADBEEF;
    @(negedge clk_32f);
    bus.data_in = 32'h01234567;
    @(negedge clk_32f);
    bus.valid_in = 1'b0;
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("[TB] FAIL two_ready_full: got %b expected 0", bus.ready_out); end
    checks++; if (bus.idle_out !== 1'b0) begin errors++; $display("[TB] FAIL two_idle_staged: got %b expected 0", bus.idle_out); end
    wait_bit(5'd31);
    wait_bit(5'd10);
    checks++; if (bus.idle_out !== 1'b0) begin errors++; $display("[TB] FAIL two_idle_sending: got %b expected 0", bus.idle_out); end
    wait_bit(5'd31);
    wait_bit(5'd31);
    @(negedge clk_32f);
    checks++;
    if (q0.size() < base + 3) begin
      errors++; $display("[TB] FAIL two_frames: got %0d frames expected %0d", q0.size() - base, 3);
    end else begin
      if (q0[base+1] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL two_lane0: got %h expected DEADBEEF", q0[base+1]); end
      checks++; if (q1[base+1] !== 32'h01234567) begin errors++; $display("[TB] FAIL two_lane1: got %h expected 01234567", q1[base+1]); end
      checks++; if (q0[base+2] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL two_after: got %h expected BCBCBCBC", q0[base+2]); end
    end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("[TB] FAIL two_idle_return: got %b expected 1", bus.idle_out); end
  endtask

  task automatic test_stream;
    logic [31:0] w [6];
    int exp_cyc [6];
    int acc_cyc [6];
    int idx;
    int base;
    w = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0, 32'h13579BDF, 32'h2468ACE0};
    exp_cyc = '{0, 1, 27, 28, 59, 60};
    acc_cyc = '{-1, -1, -1, -1, -1, -1};
    idx = 0;
    wait_bit(5'd5);
    base = q0.size();
    for (int cyc = 0; cyc < 100 && idx < 6; cyc++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = w[idx];
      if (bus.ready_out === 1'b1) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      @(negedge clk_32f);
    end
    bus.valid_in = 1'b0;
    checks++; if (idx != 6) begin errors++; $display("[TB] FAIL stream_accepts: got %0d expected 6", idx); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (acc_cyc[i] != exp_cyc[i]) begin errors++; $display("[TB] FAIL stream_accept_cycle word %0d: got %0d expected %0d", i, acc_cyc[i], exp_cyc[i]); end
    end
    wait_bit(5'd31);
    wait_bit(5'd31);
    @(negedge clk_32f);
    checks++;
    if (q0.size() < base + 4) begin
      errors++; $display("[TB] FAIL stream_frames: got %0d frames expected %0d", q0.size() - base, 4);
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++; if (q0[base+1+f] !== w[2*f]) begin errors++; $display("[TB] FAIL stream_lane0 frame %0d: got %h expected %h", f, q0[base+1+f], w[2*f]); end
        checks++; if (q1[base+1+f] !== w[2*f+1]) begin errors++; $display("[TB] FAIL stream_lane1 frame %0d: got %h expected %h", f, q1[base+1+f], w[2*f+1]); end
      end
    end
  endtask

  task automatic test_single;
    int base;
    wait_bit(5'd10);
    base = q0.size();
    bus.valid_in = 1'b1; bus.data_in = 32'hA5A5A5A5;
    @(negedge clk_32f);
    bus.valid_in = 1'b0;
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", bus.ready_out); end
    checks++; if (bus.idle_out !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b expected 0", bus.idle_out); end
    wait_bit(5'd31);
    wait_bit(5'd31);
    @(negedge clk_32f);
    checks++; if (q0[base+1] !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL single_lane0: got %h expected A5A5A5A5", q0[base+1]); end
    checks++; if (q1[base+1] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL single_lane1: got %h expected BCBCBCBC", q1[base+1]); end
    wait_bit(5'd3);
    base = q0.size();
    bus.valid_in = 1'b1; bus.data_in = 32'h5A5A0FF0;
    @(negedge clk_32f);
    bus.valid_in = 1'b0;
    wait_bit(5'd31);
    wait_bit(5'd31);
    @(negedge clk_32f);
    checks++; if (q1[base+1] !== 32'h5A5A0FF0) begin errors++; $display("[TB] FAIL single_next_lane1: got %h expected 5A5A0FF0", q1[base+1]); end
    checks++; if (q0[base+1] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL single_next_lane0: got %h expected BCBCBCBC", q0[base+1]); end
  endtask

  task automatic test_boundary;
    int base;
    wait_bit(5'd20);
    base = q0.size();
    wait_bit(5'd31);
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("[TB] FAIL boundary_ready: got %b expected 1", bus.ready_out); end
    bus.valid_in = 1'b1; bus.data_in = 32'hCAFEF00D;
    @(negedge clk_32f);
    bus.valid_in = 1'b0;
    checks++; if (bus.idle_out !== 1'b0) begin errors++; $display("[TB] FAIL boundary_idle: got %b expected 0", bus.idle_out); end
    wait_bit(5'd31);
    wait_bit(5'd31);
    @(negedge clk_32f);
    checks++; if (q0[base+1] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL boundary_first: got %h expected BCBCBCBC", q0[base+1]); end
    checks++; if (q0[base+2] !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL boundary_second: got %h expected CAFEF00D", q0[base+2]); end
    checks++; if (q1[base+2] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL boundary_lane1: got %h expected BCBCBCBC", q1[base+2]); end
  endtask

  task automatic test_reset_mid;
    int base;
    wait_bit(5'd10);
    bus.valid_in = 1'b1; bus.data_in = 32'h13572468;
    @(negedge clk_32f);
    bus.data_in = 32'h9ABCDEF0;
    @(negedge clk_32f);
    bus.valid_in = 1'b0;
    wait_bit(5'd17);
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("[TB] FAIL rmid_full: got %b expected 0", bus.ready_out); end
    checks++; if (bus.data_out0 !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pre_d0: got %b expected 0", bus.data_out0); end
    #2 reset_L = 1'b0;
    #1;
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready: got %b expected 1", bus.ready_out); end
    checks++; if (bus.data_out0 !== 1'b1) begin errors++; $display("[TB] FAIL rmid_d0: got %b expected 1", bus.data_out0); end
    checks++; if (bus.data_out1 !== 1'b1) begin errors++; $display("[TB] FAIL rmid_d1: got %b expected 1", bus.data_out1); end
    checks++; if (bus.frame_out !== 1'b1) begin errors++; $display("[TB] FAIL rmid_frame: got %b expected 1", bus.frame_out); end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("[TB] FAIL rmid_idle: got %b expected 1", bus.idle_out); end
    @(negedge clk_32f);
    reset_L = 1'b1;
    base = q0.size();
    wait_bit(5'd31);
    wait_bit(5'd31);
    @(negedge clk_32f);
    for (int f = 0; f < 2; f++) begin
      checks++; if (q0[base+f] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL rmid_lane0 frame %0d: got %h expected BCBCBCBC", f, q0[base+f]); end
      checks++; if (q1[base+f] !== 32'hBCBCBCBC) begin errors++; $display("[TB] FAIL rmid_lane1 frame %0d: got %h expected BCBCBCBC", f, q1[base+f]); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_pat     = 32'hBCBCBCBC;
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 32'h0;
    test_reset();
    test_idle();
    test_two_words();
    test_stream();
    test_single();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_tx_serial.md
PHY_TX_SERIAL -- requirements
Module: phy_tx_serial

Interface
REQ-001 SHALL have port: clk_32f  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_L  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: data_in  input  32  parallel word to transmit.
REQ-004 SHALL have port: valid_in  input  1  data_in is presented for transfer.
REQ-005 SHALL have port: ready_out  output  1  block accepts data_in at this edge.
REQ-006 SHALL have port: data_out0  output  1  serial bit stream, lane 0.
REQ-007 SHALL have port: data_out1  output  1  serial bit stream, lane 1.
REQ-008 SHALL have port: frame_out  output  1  high during bit 0 (first bit) of each 32-bit lane frame.
REQ-009 SHALL have port: idle_out  output  1  high when both staging slots are empty and both lanes are transmitting idle pattern.
REQ-010 SHALL define parameter: IDLE_BYTE, default 8'hBC, idle/COM symbol sent on a lane with no data.

Function
REQ-011 SHALL keep a free-running 5-bit bit counter bit_cnt: 0 after reset, +1 every cycle, wrapping 31->0.
REQ-012 SHALL hold two staging slots (slot0 -> lane 0, slot1 -> lane 1), each a 32-bit word plus a valid flag, and a 1-bit write pointer wr_sel.
REQ-013 SHALL drive ready_out combinationally as NOT valid flag of slot[wr_sel].
REQ-014 SHALL, on an edge with valid_in=1 and ready_out=1, write data_in into slot[wr_sel], set that slot's flag, and toggle wr_sel (striping: even words lane 0, odd words lane 1).
REQ-015 SHALL ignore data_in on edges where valid_in=0 or ready_out=0; data_in need not be held.
REQ-016 SHALL keep one 32-bit shift register per lane; data_outN equals bit 31 of lane N's shifter (registered, no combinational path from inputs).
REQ-017 SHALL, on an edge with bit_cnt != 31, shift each lane shifter left by 1.
REQ-018 SHALL, on the edge with bit_cnt == 31, load each lane shifter from its slot if the slot flag is set (then clear the flag), else with {4{IDLE_BYTE}}.
REQ-019 SHALL transmit word bytes [31:24],[23:16],[15:8],[7:0] in that order, each byte MSB first; both lanes frame-aligned.
REQ-020 SHALL, on an edge with bit_cnt == 31 where an empty slot is written at the same edge, load the idle pattern into that lane's shifter and keep the new word in the slot for the next frame.
REQ-021 SHALL never write a slot whose flag is set; a full slot stalls input (ready_out=0) until its frame-boundary load clears it.
REQ-022 SHALL drive frame_out = 1 exactly when bit_cnt == 0.
REQ-023 SHALL drive idle_out = 1 when both slot flags are clear and both shifters were last loaded with the idle pattern (or are at reset value).
REQ-024 SHALL have latency: a word accepted during frame k appears on its lane starting the first cycle of frame k+1 (or k+2 if accepted at the bit_cnt==31 edge), 32 cycles per word.

Reset
REQ-025 SHALL, while reset_L=0, asynchronously force: bit_cnt=0, wr_sel=0, both slot flags clear, both shifters={4{IDLE_BYTE}}.
REQ-026 SHALL therefore present after reset: ready_out=1, data_out0=data_out1=1 (MSB of 8'hBC), frame_out=1, idle_out=1.
REQ-027 SHALL, on reset assertion mid-frame, discard staged and in-flight words; transmission restarts at bit_cnt=0 with idle pattern after release.

Verification
REQ-028 SHALL cover: no valid_in for 64 cycles after reset -> both lanes repeat 10111100 continuously, idle_out=1, frame_out every 32 cycles.
REQ-029 SHALL cover: accept 32'hDEADBEEF then 32'h01234567 in frame 0 -> frame 1 lane 0 serializes DEADBEEF, lane 1 serializes 01234567, MSB first, idle_out=0.
REQ-030 SHALL cover: valid_in held high with 6 distinct words -> ready_out drops after 2 accepts, only 2 words per frame, order lane0/lane1 alternating, no loss or duplication.
REQ-031 SHALL cover: single word 32'hA5A5A5A5 accepted -> lane 0 sends it next frame while lane 1 sends BCBCBCBC; next accepted word goes to lane 1.
REQ-032 SHALL cover: word written to empty slot exactly at the bit_cnt==31 edge -> idle sent that frame, word sent the following frame.
REQ-033 SHALL cover: reset_L pulsed low at bit_cnt=17 with both slots full -> outputs immediately return to reset values, staged words never transmitted.
